// File: rtl/crossbar_pkg.sv
// Shared types for the output scheduler: FSM state, VC head word, defaults.
// Index-width helper keeps rr_pick and the top in agreement.
package crossbar_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_XFER,
    S_GAP
  } sched_state_e;

  typedef struct packed {
    logic       eof;
    logic [7:0] data;
  } vc_word_t;

  localparam int unsigned C_DEFAULT_IFG = 12;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [15:0] sat_inc16(
    input logic [15:0] v
  );
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/output_scheduler_if.sv
// VC-queue side and tx side of the output scheduler as one bundle.
// slave = scheduler, master = queues/tx environment.
interface output_scheduler_if #(
  parameter int P_WIDTH = 3
);

  logic [P_WIDTH-1:0]   vc_valid_i;
  logic [P_WIDTH*9-1:0] vc_data_i;
  logic [P_WIDTH-1:0]   vc_rd_o;
  logic [7:0]           tx_data_o;
  logic                 tx_ctrl_o;
  logic                 busy_o;
  logic [15:0]          pkt_cnt_o;

  modport master (
    output vc_valid_i,
    output vc_data_i,
    input  vc_rd_o,
    input  tx_data_o,
    input  tx_ctrl_o,
    input  busy_o,
    input  pkt_cnt_o
  );

  modport slave (
    input  vc_valid_i,
    input  vc_data_i,
    output vc_rd_o,
    output tx_data_o,
    output tx_ctrl_o,
    output busy_o,
    output pkt_cnt_o
  );

endinterface

// File: rtl/output_scheduler_rr_pick.sv
// Round-robin search: first set request strictly after last_i,
// wrapping, with last_i itself checked last.
module rr_pick
  import crossbar_pkg::*;
#(
  parameter int P_WIDTH = 3,
  localparam int IW = idx_w(P_WIDTH)
) (
  input  logic [P_WIDTH-1:0] req_i,
  input  logic [IW-1:0]      last_i,
  output logic               found_o,
  output logic [IW-1:0]      idx_o
);

  // Walk downward so the nearest candidate overwrites farther ones.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    for (int k = P_WIDTH; k >= 1; k--) begin
      if (req_i[(int'(last_i) + k) % P_WIDTH]) begin
        found_o = 1'b1;
        idx_o   = IW'((int'(last_i) + k) % P_WIDTH);
      end
    end
  end

endmodule

// File: rtl/output_scheduler.sv
// Round-robin packet scheduler: P_WIDTH VC queues onto one tx port.
// Define OUTPUT_SCHEDULER_IFG_EN to insert P_IFG_CYCLES gap after eof.
module output_scheduler
  import crossbar_pkg::*;
#(
  parameter int P_WIDTH      = 3,
  parameter int P_IFG_CYCLES = C_DEFAULT_IFG
) (
  input logic clk_i,
  input logic rst_i,
  output_scheduler_if.slave sched_io
);

  localparam int IW = idx_w(P_WIDTH);

  sched_state_e state_q, state_d;
  logic [IW-1:0] grant_q, grant_d;
  logic [IW-1:0] last_q, last_d;
  logic [15:0]   pkt_cnt_q, pkt_cnt_d;

`ifdef OUTPUT_SCHEDULER_IFG_EN
  localparam logic [7:0] C_GAP_LOAD = 8'(P_IFG_CYCLES - 1);
  logic [7:0] gap_q, gap_d;
`endif

  vc_word_t [P_WIDTH-1:0] words;
  vc_word_t      g_word;
  logic          g_valid;
  logic          eof_fire;
  logic          pick_found;
  logic [IW-1:0] pick_idx;

  assign words    = sched_io.vc_data_i;
  assign g_word   = words[grant_q];
  assign g_valid  = sched_io.vc_valid_i[grant_q];
  assign eof_fire = (state_q == S_XFER) && g_valid
                    && g_word.eof;

  rr_pick #(
    .P_WIDTH(P_WIDTH)
  ) u_pick (
    .req_i  (sched_io.vc_valid_i),
    .last_i (last_q),
    .found_o(pick_found),
    .idx_o  (pick_idx)
  );

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    pkt_cnt_d = pkt_cnt_q;
`ifdef OUTPUT_SCHEDULER_IFG_EN
    gap_d     = gap_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          grant_d = pick_idx;
          state_d = S_XFER;
        end
      end
      S_XFER: begin
        if (eof_fire) begin
          last_d    = grant_q;
          pkt_cnt_d = sat_inc16(pkt_cnt_q);
`ifdef OUTPUT_SCHEDULER_IFG_EN
          state_d   = S_GAP;
          gap_d     = C_GAP_LOAD;
`else
          state_d   = S_IDLE;
`endif
        end
      end
      S_GAP: begin
`ifdef OUTPUT_SCHEDULER_IFG_EN
        if (gap_q == 8'd0) begin
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q - 8'd1;
        end
`else
        state_d = S_IDLE;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      grant_q   <= '0;
      last_q    <= IW'(P_WIDTH - 1);
      pkt_cnt_q <= '0;
`ifdef OUTPUT_SCHEDULER_IFG_EN
      gap_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      pkt_cnt_q <= pkt_cnt_d;
`ifdef OUTPUT_SCHEDULER_IFG_EN
      gap_q     <= gap_d;
`endif
    end
  end

  // tx path is combinational so an underrun drops ctrl the same cycle.
  always_comb begin
    sched_io.vc_rd_o   = '0;
    sched_io.tx_ctrl_o = 1'b0;
    sched_io.tx_data_o = 8'h00;
    if (state_q == S_XFER) begin
      sched_io.vc_rd_o[grant_q] = g_valid;
      sched_io.tx_ctrl_o        = g_valid;
      if (g_valid) begin
        sched_io.tx_data_o = g_word.data;
      end
    end
  end

  assign sched_io.busy_o    = (state_q != S_IDLE);
  assign sched_io.pkt_cnt_o = pkt_cnt_q;

endmodule

// File: doc/output_scheduler.md
OUTPUT_SCHEDULER -- requirements
Module: output_scheduler

Interface
REQ-001 SHALL have parameter P_WIDTH, default 3, number of virtual-channel (VC) requesters feeding one tx port.
REQ-002 SHALL have parameter P_IFG_CYCLES, default 12, idle cycles inserted after each packet (range 1..255).
REQ-003 SHALL have port clk_i  in  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst_i  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port vc_valid_i  in  P_WIDTH  per VC: FWFT queue non-empty, head byte present.
REQ-006 SHALL have port vc_data_i  in  P_WIDTH*9  per VC head word {eof,data[7:0]}; VC k occupies bits [9k+8:9k].
REQ-007 SHALL have port vc_rd_o  out  P_WIDTH  one-hot pop strobe to the granted VC queue.
REQ-008 SHALL have port tx_data_o  out  8  byte to the tx port.
REQ-009 SHALL have port tx_ctrl_o  out  1  high with every valid tx byte.
REQ-010 SHALL have port busy_o  out  1  high in XFER or GAP.
REQ-011 SHALL have port pkt_cnt_o  out  16  packets completed since reset, saturating at 16'hFFFF.

Function
REQ-012 SHALL implement FSM states IDLE, XFER, GAP; reset state IDLE.
REQ-013 IDLE: if any vc_valid_i bit set, SHALL register grant index g = first set bit searching upward (wrapping) from last_g+1, enter XFER next cycle; else stay IDLE.
REQ-014 Arbitration latency SHALL be exactly one cycle: valid seen in IDLE at cycle t -> first tx byte at t+1 if still valid.
REQ-015 XFER: vc_rd_o[g] = vc_valid_i[g], all other bits 0; tx_ctrl_o = vc_valid_i[g]; tx_data_o = vc_data_i[g][7:0] when tx_ctrl_o, else 8'h00 (combinational from state, g, inputs).
REQ-016 XFER, vc_valid_i[g]=0 (underrun): SHALL hold grant, drive vc_rd_o=0, tx_ctrl_o=0; other VCs SHALL NOT be granted until eof.
REQ-017 XFER, vc_valid_i[g]=1 and eof bit set: that byte SHALL be sent and popped; next state GAP (macro defined) or IDLE; last_g <= g; pkt_cnt_o increments.
REQ-018 GAP: 8-bit counter loaded with P_IFG_CYCLES-1 on entry, decrements each cycle; SHALL exit to IDLE the cycle after it reads 0; vc_rd_o=0, tx_ctrl_o=0 throughout.
REQ-019 Outside XFER, vc_rd_o SHALL be 0, tx_ctrl_o 0, tx_data_o 8'h00.
REQ-020 Round-robin pointer last_g SHALL reset to P_WIDTH-1 so VC 0 has first priority after reset.
REQ-021 Requests arriving during XFER/GAP SHALL be held off (not lost); the queue keeps them.
REQ-022 pkt_cnt_o SHALL NOT wrap: at 16'hFFFF further eofs leave it unchanged.

Reset
REQ-023 rst_i asserted at any time, including mid-packet, SHALL immediately force IDLE, vc_rd_o=0, tx_ctrl_o=0, tx_data_o=8'h00, busy_o=0, pkt_cnt_o=0, gap counter 0, last_g=P_WIDTH-1; the partial packet is abandoned.
REQ-024 First arbitration SHALL occur on the first rising edge after rst_i deasserts.

Configuration
REQ-025 Macro OUTPUT_SCHEDULER_IFG_EN: defined -> GAP state and counter present per REQ-018; undefined -> XFER eof goes directly to IDLE, no counter logic, P_IFG_CYCLES ignored.

Structure
REQ-026 Shared package crossbar_pkg SHALL hold the FSM state enum (sched_state_e), the 9-bit VC word typedef and C_DEFAULT_IFG=12.
REQ-027 Round-robin next-grant search SHALL be a combinational sub-module rr_pick (inputs: request vector, last_g; outputs: found, index).

Verification
REQ-028 Single VC: VC1 presents 4-byte packet 0x11,0x22,0x33,0x44(eof) -> tx bytes on 4 consecutive cycles starting 1 cycle after valid, then 12 idle cycles, pkt_cnt_o=1.
REQ-029 Fairness: VC0,VC1,VC2 all hold 2-byte packets continuously -> grant order 0,1,2,0,1,2; no interleaving of bytes within a packet.
REQ-030 Underrun: VC2 valid drops for 3 cycles mid-packet while VC0 valid -> tx_ctrl_o low 3 cycles, vc_rd_o[0] never asserted until VC2 eof.
REQ-031 Reset mid-packet: assert rst_i on byte 2 of 5 -> outputs zero same cycle, after release VC0 granted first.
REQ-032 Macro off: two back-to-back VC0 packets -> exactly one idle cycle (IDLE arbitration) between eof and next first byte.
REQ-033 Saturation: force 65536 single-byte packets -> pkt_cnt_o stays 16'hFFFF.
